// File: rtl/dbus_fifo_responder_pkg.sv
// Shared definitions for the data-bus FIFO responder: register offsets
// within the 16-byte window and bit positions inside STATUS, RXDATA and CTRL.
package dbus_fifo_responder_pkg;

   typedef enum logic [1:0] {
      REG_STATUS = 2'd0,
      REG_RXDATA = 2'd1,
      REG_TXDATA = 2'd2,
      REG_CTRL   = 2'd3
   } regOffset_e;

   // STATUS bit positions
   localparam int ST_RX_EMPTY     = 0;
   localparam int ST_RX_FULL      = 1;
   localparam int ST_TX_EMPTY     = 2;
   localparam int ST_TX_FULL      = 3;
   localparam int ST_TX_OVF       = 4;
   localparam int ST_RX_COUNT_LSB = 8;
   localparam int ST_TX_COUNT_LSB = 16;

   // RXDATA valid flag position
   localparam int RXDATA_VALID = 31;

   // CTRL bit positions; only irq_en is stored, the others are strobes
   localparam int CTRL_RX_FLUSH  = 0;
   localparam int CTRL_TX_FLUSH  = 1;
   localparam int CTRL_IRQ_EN    = 2;
   localparam int CTRL_OVF_CLEAR = 3;

endpackage

// File: rtl/dbus_fifo_responder_sync_fifo.sv
// Single-clock FIFO with combinational head output. Flush has priority over
// a same-cycle push or pop. The head reads as zero while the FIFO is empty.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wrPtr;
   logic [DEPTH_LOG2-1:0] rdPtr;
   logic                  doPush;
   logic                  doPop;

   assign empty  = (count == '0);
   assign full   = (count == FULL_COUNT);
   assign doPush = push & ~full;
   assign doPop  = pop & ~empty;
   assign dout   = empty ? '0 : mem[rdPtr];

   // Pointer and occupancy bookkeeping; pointers wrap modulo depth
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because empty masks the head
   always_ff @(posedge clk) begin
      if (doPush && !flush) mem[wrPtr] <= din;
   end

endmodule

// File: rtl/dbus_fifo_responder.sv
// Memory-mapped bus target bridging CPU accesses to an RX byte stream
// (from a producer) and a TX byte stream (to a consumer), with a level IRQ
// while RX data is pending.
module dbus_fifo_responder
   import dbus_fifo_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'hFF20_0000,
   parameter int          DEPTH_LOG2 = 4
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        DwReadEnable,
   input  logic        DwWriteEnable,
   input  logic [3:0]  DwByteEnable,
   input  logic [31:0] DwAddress,
   input  logic [31:0] DwWriteData,
   output logic [31:0] DwReadData,
   output logic        oSelected,
   input  logic [7:0]  iRxData,
   input  logic        iRxValid,
   output logic        oRxReady,
   output logic [7:0]  oTxData,
   output logic        oTxValid,
   input  logic        iTxReady,
   output logic        oIRQ
);

   regOffset_e            regOffset;
   logic                  writeCommit;
   logic                  ctrlWrite;
   logic                  txWriteReq;
   logic                  rxPush;
   logic                  rxPop;
   logic                  rxFlush;
   logic                  txPush;
   logic                  txPop;
   logic                  txFlush;
   logic                  ovfClear;
   logic                  ovfEvent;
   logic                  rxEmpty;
   logic                  rxFull;
   logic                  txEmpty;
   logic                  txFull;
   logic [7:0]            rxHead;
   logic [DEPTH_LOG2:0]   rxCount;
   logic [DEPTH_LOG2:0]   txCount;
   logic                  irqEn;
   logic                  txOverflow;
   logic                  unusedBits;

   assign oSelected   = (DwAddress[31:4] == BASE_ADDR[31:4]);
   assign regOffset   = regOffset_e'(DwAddress[3:2]);
   assign writeCommit = oSelected & DwWriteEnable & DwByteEnable[0];
   assign ctrlWrite   = writeCommit & (regOffset == REG_CTRL);
   assign txWriteReq  = writeCommit & (regOffset == REG_TXDATA);

   assign rxFlush  = ctrlWrite & DwWriteData[CTRL_RX_FLUSH];
   assign txFlush  = ctrlWrite & DwWriteData[CTRL_TX_FLUSH];
   assign ovfClear = ctrlWrite & DwWriteData[CTRL_OVF_CLEAR];

   assign oRxReady = ~rxFull;
   assign rxPush   = iRxValid & oRxReady;
   assign rxPop    = oSelected & DwReadEnable & (regOffset == REG_RXDATA) & ~rxEmpty;

   assign oTxValid = ~txEmpty;
   assign txPop    = oTxValid & iTxReady;
   assign txPush   = txWriteReq & ~txFull;
   assign ovfEvent = txWriteReq & txFull;

   assign unusedBits = ^{DwWriteData[31:8], DwByteEnable[3:1], DwAddress[1:0]};

   sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) rxFifo (
      .clk   (iCLK),
      .rstN  (iRST),
      .push  (rxPush),
      .pop   (rxPop),
      .flush (rxFlush),
      .din   (iRxData),
      .dout  (rxHead),
      .empty (rxEmpty),
      .full  (rxFull),
      .count (rxCount)
   );

   sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) txFifo (
      .clk   (iCLK),
      .rstN  (iRST),
      .push  (txPush),
      .pop   (txPop),
      .flush (txFlush),
      .din   (DwWriteData[7:0]),
      .dout  (oTxData),
      .empty (txEmpty),
      .full  (txFull),
      .count (txCount)
   );

   // Zero-wait-state read mux; unselected or write-only offsets read as zero
   always_comb begin
      DwReadData = '0;
      if (oSelected) begin
         case (regOffset)
            REG_STATUS: begin
               DwReadData[ST_RX_EMPTY] = rxEmpty;
               DwReadData[ST_RX_FULL]  = rxFull;
               DwReadData[ST_TX_EMPTY] = txEmpty;
               DwReadData[ST_TX_FULL]  = txFull;
               DwReadData[ST_TX_OVF]   = txOverflow;
               DwReadData[ST_RX_COUNT_LSB +: DEPTH_LOG2 + 1] = rxCount;
               DwReadData[ST_TX_COUNT_LSB +: DEPTH_LOG2 + 1] = txCount;
            end
            REG_RXDATA: begin
               DwReadData[7:0]          = rxHead;
               DwReadData[RXDATA_VALID] = ~rxEmpty;
            end
            REG_CTRL: DwReadData[CTRL_IRQ_EN] = irqEn;
            default:  DwReadData = '0;
         endcase
      end
   end

   // Stored interrupt enable, written through CTRL
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST)          irqEn <= 1'b0;
      else if (ctrlWrite) irqEn <= DwWriteData[CTRL_IRQ_EN];
   end

   // Sticky TX overflow; a same-cycle overflow beats the clear strobe
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST)         txOverflow <= 1'b0;
      else if (ovfEvent) txOverflow <= 1'b1;
      else if (ovfClear) txOverflow <= 1'b0;
   end

   // Registered level interrupt, one cycle behind irq_en / rx_empty
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) oIRQ <= 1'b0;
      else       oIRQ <= irqEn & ~rxEmpty;
   end

endmodule
